// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle control sequencer for an RV32I core.
//
// Steps IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH and drives every
// datapath strobe and mux select combinationally from the registered state and the
// latched instruction register. One shared memory port serves both instruction fetch
// and data access through a mem_req / mem_ready handshake.
//
// Ports:
//   clk          in   core clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ir[31:0]     in   instruction register (loaded by the datapath on ir_we)
//   mem_ready    in   memory completed the current request this cycle
//   br_taken     in   branch comparator result for the branch in ir
//   pc_we        out  PC write enable
//   pc_src[1:0]  out  00 PC+4, 01 ALU result, 10 ALU result with bit 0 cleared
//   ir_we        out  load ir from memory read data and latch old_pc
//   imm_sel[2:0] out  001 I, 010 S, 011 B, 100 U, 101 J, 000 none
//   alu_a_sel    out  0 rs1, 1 old_pc
//   alu_b_sel    out  0 rs2, 1 immediate
//   alu_op[1:0]  out  00 add, 01 funct3/funct7 decoded, 10 pass B
//   mem_req      out  memory request valid
//   mem_we       out  store when set, load otherwise
//   mem_addr_sel out  0 PC, 1 ALU result
//   rf_we        out  register-file write enable
//   wb_sel[1:0]  out  00 ALU, 01 load data, 10 PC (already PC+4)
//   state[2:0]   out  IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6
//   trap         out  illegal-instruction flag (only with RISCV_MC_CTRL_TRAP_EN)
//
// Configuration macro RISCV_MC_CTRL_TRAP_EN: when defined, illegal instructions send
// DECODE to a sticky TRAP state; when undefined they execute as a NOP.

module riscv_mc_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   input  logic        br_taken,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        ir_we,
   output logic [2:0]  imm_sel,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [1:0]  alu_op,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic [2:0]  state
`ifdef RISCV_MC_CTRL_TRAP_EN
   ,
   output logic        trap
`endif
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StTrap   = 3'd6
   } state_e;

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [6:0] OpcLoad  = 7'b0000011;
   localparam logic [6:0] OpcStore = 7'b0100011;
   localparam logic [6:0] OpcBr    = 7'b1100011;
   localparam logic [6:0] OpcJal   = 7'b1101111;
   localparam logic [6:0] OpcJalr  = 7'b1100111;
   localparam logic [6:0] OpcLui   = 7'b0110111;
   localparam logic [6:0] OpcAuipc = 7'b0010111;

   localparam logic [2:0] ImmNone = 3'b000;
   localparam logic [2:0] ImmI    = 3'b001;
   localparam logic [2:0] ImmS    = 3'b010;
   localparam logic [2:0] ImmB    = 3'b011;
   localparam logic [2:0] ImmU    = 3'b100;
   localparam logic [2:0] ImmJ    = 3'b101;

   state_e state_q, state_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_load;
   logic       is_store;
   logic       illegal;
   logic [2:0] imm_fmt;
   logic       alu_a_x;
   logic       alu_b_x;
   logic [1:0] alu_op_x;

   // Only opcode and funct3 steer control; the remaining fields belong to the datapath.
   logic unused_ir;
   assign unused_ir = ^{ir[31:15], ir[11:7]};

   assign opcode   = ir[6:0];
   assign funct3   = ir[14:12];
   assign is_load  = (opcode == OpcLoad);
   assign is_store = (opcode == OpcStore);

   // Legality: unknown opcode, or a reserved funct3 for BRANCH / LOAD / STORE.
   always_comb begin
      illegal = 1'b0;
      case (opcode)
         OpcOp, OpcOpImm, OpcJal, OpcJalr, OpcLui, OpcAuipc: illegal = 1'b0;
         OpcBr:    illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
         OpcLoad:  illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         OpcStore: illegal = (funct3 > 3'b010);
         default:  illegal = 1'b1;
      endcase
   end

   // Immediate format and ALU operand/op selects, per opcode. These are held through
   // MEM and WB as well so the ALU result (address or write-back value) stays valid.
   always_comb begin
      imm_fmt  = ImmNone;
      alu_a_x  = 1'b0;
      alu_b_x  = 1'b0;
      alu_op_x = 2'b00;
      case (opcode)
         OpcOp: begin
            alu_op_x = 2'b01;
         end
         OpcOpImm: begin
            imm_fmt  = ImmI;
            alu_b_x  = 1'b1;
            alu_op_x = 2'b01;
         end
         OpcLoad: begin
            imm_fmt = ImmI;
            alu_b_x = 1'b1;
         end
         OpcStore: begin
            imm_fmt = ImmS;
            alu_b_x = 1'b1;
         end
         OpcBr: begin
            imm_fmt = ImmB;
            alu_a_x = 1'b1;
            alu_b_x = 1'b1;
         end
         OpcJal: begin
            imm_fmt = ImmJ;
            alu_a_x = 1'b1;
            alu_b_x = 1'b1;
         end
         OpcJalr: begin
            imm_fmt = ImmI;
            alu_b_x = 1'b1;
         end
         OpcLui: begin
            imm_fmt  = ImmU;
            alu_b_x  = 1'b1;
            alu_op_x = 2'b10;
         end
         OpcAuipc: begin
            imm_fmt = ImmU;
            alu_a_x = 1'b1;
            alu_b_x = 1'b1;
         end
         default: begin
            imm_fmt = ImmNone;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_we        = 1'b0;
      pc_src       = 2'b00;
      ir_we        = 1'b0;
      imm_sel      = ImmNone;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      alu_op       = 2'b00;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      rf_we        = 1'b0;
      wb_sel       = 2'b00;

      case (state_q)
         StIdle: begin
            state_d = StFetch;
         end

         StFetch: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = StDecode;
            end
         end

         StDecode: begin
            imm_sel = imm_fmt;
`ifdef RISCV_MC_CTRL_TRAP_EN
            state_d = illegal ? StTrap : StExec;
`else
            state_d = StExec;
`endif
         end

         StExec: begin
            // Illegal instructions fall through with no strobes: a NOP, PC already +4.
            state_d = StFetch;
            if (!illegal) begin
               imm_sel   = imm_fmt;
               alu_a_sel = alu_a_x;
               alu_b_sel = alu_b_x;
               alu_op    = alu_op_x;
               case (opcode)
                  OpcLoad, OpcStore: begin
                     state_d = StMem;
                  end
                  OpcOp, OpcOpImm, OpcLui, OpcAuipc: begin
                     state_d = StWb;
                  end
                  OpcBr: begin
                     pc_we  = br_taken;
                     pc_src = 2'b01;
                  end
                  OpcJal: begin
                     pc_we  = 1'b1;
                     pc_src = 2'b01;
                     rf_we  = 1'b1;
                     wb_sel = 2'b10;
                  end
                  OpcJalr: begin
                     pc_we  = 1'b1;
                     pc_src = 2'b10;
                     rf_we  = 1'b1;
                     wb_sel = 2'b10;
                  end
                  default: begin
                     state_d = StFetch;
                  end
               endcase
            end
         end

         StMem: begin
            imm_sel      = imm_fmt;
            alu_a_sel    = alu_a_x;
            alu_b_sel    = alu_b_x;
            alu_op       = alu_op_x;
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = is_store;
            if (mem_ready) begin
               state_d = is_store ? StFetch : StWb;
            end
         end

         StWb: begin
            imm_sel   = imm_fmt;
            alu_a_sel = alu_a_x;
            alu_b_sel = alu_b_x;
            alu_op    = alu_op_x;
            rf_we     = 1'b1;
            wb_sel    = is_load ? 2'b01 : 2'b00;
            state_d   = StFetch;
         end

`ifdef RISCV_MC_CTRL_TRAP_EN
         StTrap: begin
            // Sticky until reset; every strobe stays at its default of 0.
            state_d = StTrap;
         end
`endif

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign state = state_q;

`ifdef RISCV_MC_CTRL_TRAP_EN
   assign trap = (state_q == StTrap);
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: latency table, per-cycle trace model with
// randomized instructions and memory wait states, and hand-written corner sequences.

module tb_riscv_mc_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] ir;
   logic        mem_ready;
   logic        br_taken;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic        ir_we;
   logic [2:0]  imm_sel;
   logic        alu_a_sel;
   logic        alu_b_sel;
   logic [1:0]  alu_op;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic [2:0]  state;
`ifdef RISCV_MC_CTRL_TRAP_EN
   logic        trap;
`endif

   riscv_mc_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ir           (ir),
      .mem_ready    (mem_ready),
      .br_taken     (br_taken),
      .pc_we        (pc_we),
      .pc_src       (pc_src),
      .ir_we        (ir_we),
      .imm_sel      (imm_sel),
      .alu_a_sel    (alu_a_sel),
      .alu_b_sel    (alu_b_sel),
      .alu_op       (alu_op),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .state        (state)
`ifdef RISCV_MC_CTRL_TRAP_EN
      ,
      .trap         (trap)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [19:0] MAll   = 20'hFFFFF;
   localparam logic [19:0] MNoAlu = 20'hFE03F;  // imm_sel and ALU selects not checked
   localparam logic [19:0] MNoB   = 20'hFFEFF;  // alu_b_sel not checked

   typedef struct {
      bit          rdy;
      logic [19:0] exp;
      logic [19:0] msk;
   } cyc_t;

   typedef struct {
      string       name;
      logic [31:0] ir;
      bit          br;
      int          lat;
      logic [2:0]  imm;
   } vec_t;

   cyc_t q[$];
   vec_t tbl[$];
   int   checks;
   int   failures;
   int   mem_cycles;

   function automatic logic [19:0] mk(logic [2:0] st, logic pcwe, logic [1:0] pcsrc,
                                      logic irwe, logic [2:0] imm, logic a, logic b,
                                      logic [1:0] op, logic req, logic we, logic asel,
                                      logic rfwe, logic [1:0] wb);
      return {st, pcwe, pcsrc, irwe, imm, a, b, op, req, we, asel, rfwe, wb};
   endfunction

   function automatic logic [19:0] dut_vec();
      return {state, pc_we, pc_src, ir_we, imm_sel, alu_a_sel, alu_b_sel, alu_op,
              mem_req, mem_we, mem_addr_sel, rf_we, wb_sel};
   endfunction

   function automatic bit is_legal(logic [31:0] i);
      logic [6:0] o;
      logic [2:0] f;
      o = i[6:0];
      f = i[14:12];
      if (o == 7'b1100011) return !(f inside {3'd2, 3'd3});
      if (o == 7'b0000011) return !(f inside {3'd3, 3'd6, 3'd7});
      if (o == 7'b0100011) return f <= 3'd2;
      return o inside {7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111,
                       7'b0010111};
   endfunction

   function automatic logic [2:0] fmt_of(logic [6:0] o);
      case (o)
         7'b0010011, 7'b0000011, 7'b1100111: return 3'b001;
         7'b0100011:                         return 3'b010;
         7'b1100011:                         return 3'b011;
         7'b0110111, 7'b0010111:             return 3'b100;
         7'b1101111:                         return 3'b101;
         default:                            return 3'b000;
      endcase
   endfunction

   task automatic push(bit rdy, logic [19:0] e, logic [19:0] m);
      cyc_t c;
      c.rdy = rdy;
      c.exp = e;
      c.msk = m;
      q.push_back(c);
   endtask

   // Expected cycle-by-cycle trace of one instruction, starting in FETCH.
   task automatic build(logic [31:0] i, bit br, int fw, int mw);
      logic [6:0]  o;
      logic [19:0] e;
      logic [19:0] m;
      bit          lg;
      bit          ld;
      bit          st;
      o  = i[6:0];
      lg = is_legal(i);
      ld = lg && (o == 7'b0000011);
      st = lg && (o == 7'b0100011);
      q.delete();
      for (int k = 0; k < fw; k++) push(1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), MAll);
      push(1'b1, mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0), MAll);
      push(1'($urandom_range(0, 1)), mk(2, 0, 0, 0, fmt_of(o), 0, 0, 0, 0, 0, 0, 0, 0), MAll);
`ifdef RISCV_MC_CTRL_TRAP_EN
      if (!lg) begin
         for (int k = 0; k < 12; k++)
            push(1'($urandom_range(0, 1)), mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MAll);
         return;
      end
`endif
      m = MAll;
      e = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (lg) begin
         case (o)
            7'b0110011: e = mk(3, 0, 0, 0, 1 - 1, 0, 0, 2'b01, 0, 0, 0, 0, 0);
            7'b0010011: e = mk(3, 0, 0, 0, 3'b001, 0, 1, 2'b01, 0, 0, 0, 0, 0);
            7'b0000011: e = mk(3, 0, 0, 0, 3'b001, 0, 1, 2'b00, 0, 0, 0, 0, 0);
            7'b0100011: e = mk(3, 0, 0, 0, 3'b010, 0, 1, 2'b00, 0, 0, 0, 0, 0);
            7'b1100011: e = mk(3, br, 2'b01, 0, 3'b011, 1, 1, 2'b00, 0, 0, 0, 0, 0);
            7'b1101111: begin
               e = mk(3, 1, 2'b01, 0, 3'b101, 1, 0, 2'b00, 0, 0, 0, 1, 2'b10);
               m = MNoB;
            end
            7'b1100111: begin
               e = mk(3, 1, 2'b10, 0, 3'b001, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10);
               m = MNoB;
            end
            7'b0110111: begin
               e = mk(3, 0, 0, 0, 3'b100, 0, 0, 2'b10, 0, 0, 0, 0, 0);
               m = MNoB;
            end
            default: begin
               e = mk(3, 0, 0, 0, 3'b100, 1, 0, 2'b00, 0, 0, 0, 0, 0);
               m = MNoB;
            end
         endcase
      end
      push(1'($urandom_range(0, 1)), e, m);
      if (ld || st) begin
         e = mk(4, 0, 0, 0, 0, 0, 0, 0, 1, st, 1, 0, 0);
         for (int k = 0; k < mw; k++) push(1'b0, e, MNoAlu);
         push(1'b1, e, MNoAlu);
      end
      if (lg && !st && (o inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                  7'b0000011}))
         push(1'($urandom_range(0, 1)), mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {1'b0, ld}),
              MNoAlu);
   endtask

   task automatic check(string nm, logic [19:0] e, logic [19:0] m);
      logic [19:0] got;
      bit          ok;
      got = dut_vec();
      ok  = ((got & m) === (e & m));
`ifdef RISCV_MC_CTRL_TRAP_EN
      if (trap !== (e[19:17] == 3'd6)) ok = 1'b0;
`endif
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %05h required %05h (mask %05h) at %0t", nm, got, e, m, $time);
      end
   endtask

   // Called at a falling edge; drives each cycle, checks 1 ns later, waits a cycle.
   task automatic play(string nm);
      foreach (q[k]) begin
         mem_ready = q[k].rdy;
         #1;
         check(nm, q[k].exp, q[k].msk);
         if (state == 3'd4) mem_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic run_instr(string nm, logic [31:0] i, bit br, int fw, int mw);
      ir       = i;
      br_taken = br;
      build(i, br, fw, mw);
      play(nm);
   endtask

   task automatic measure(vec_t v);
      int         n;
      logic [2:0] cap;
      ir       = v.ir;
      br_taken = v.br;
      n        = 0;
      cap      = 3'b111;
      do begin
         mem_ready = 1'b1;
         #1;
         if (state == 3'd3) cap = imm_sel;
         n++;
         @(negedge clk);
      end while (n < 20 && state != 3'd1);
      checks++;
      if (n != v.lat) begin
         failures++;
         $display("FAIL latency_%s: got %0d cycles required %0d", v.name, n, v.lat);
      end
      checks++;
      if (cap !== v.imm) begin
         failures++;
         $display("FAIL exec_imm_%s: got %b required %b", v.name, cap, v.imm);
      end
   endtask

   function automatic vec_t mkv(string n, logic [31:0] i, bit br, int lat, logic [2:0] imm);
      vec_t v;
      v.name = n;
      v.ir   = i;
      v.br   = br;
      v.lat  = lat;
      v.imm  = imm;
      return v;
   endfunction

   initial begin
      logic [6:0]  opcs [10];
      logic [31:0] ri;
      checks     = 0;
      failures   = 0;
      mem_cycles = 0;
      opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
               7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

      tbl.push_back(mkv("add",   32'h002081B3, 1'b0, 4, 3'b000));
      tbl.push_back(mkv("addi",  32'h00A08093, 1'b0, 4, 3'b001));
      tbl.push_back(mkv("lw",    32'h0000A103, 1'b0, 5, 3'b001));
      tbl.push_back(mkv("sw",    32'h0020A023, 1'b0, 4, 3'b010));
      tbl.push_back(mkv("beq_t", 32'h00208463, 1'b1, 3, 3'b011));
      tbl.push_back(mkv("beq_n", 32'h00208463, 1'b0, 3, 3'b011));
      tbl.push_back(mkv("jal",   32'h008000EF, 1'b0, 3, 3'b101));
      tbl.push_back(mkv("jalr",  32'h000080E7, 1'b0, 3, 3'b001));
      tbl.push_back(mkv("lui",   32'h123450B7, 1'b0, 4, 3'b100));
      tbl.push_back(mkv("auipc", 32'h00001097, 1'b0, 4, 3'b100));
`ifndef RISCV_MC_CTRL_TRAP_EN
      tbl.push_back(mkv("ill",   32'h0000007F, 1'b0, 3, 3'b000));
      tbl.push_back(mkv("brres", 32'h00002063, 1'b0, 3, 3'b000));
`endif

      // Reset: every output 0 while rst_n is low, one IDLE cycle after release.
      rst_n     = 1'b0;
      ir        = 32'h0;
      mem_ready = 1'b1;
      br_taken  = 1'b0;
      #1;
      check("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MAll);
      @(negedge clk);
      @(negedge clk);
      check("reset_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MAll);
      rst_n = 1'b1;
      #1;
      check("idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MAll);
      @(negedge clk);

      foreach (tbl[k]) measure(tbl[k]);

      // Load with two MEM wait cycles: MEM spans three cycles, then WB selects load data.
      mem_cycles = 0;
      run_instr("lw_wait", 32'h0000A103, 1'b0, 1, 2);
      checks++;
      if (mem_cycles != 3) begin
         failures++;
         $display("FAIL lw_mem_cycles: got %0d required 3", mem_cycles);
      end

      run_instr("add_trace",  32'h002081B3, 1'b0, 0, 0);
      run_instr("beq_taken",  32'h00208463, 1'b1, 0, 0);
      run_instr("beq_not",    32'h00208463, 1'b0, 0, 0);
      run_instr("jalr_trace", 32'h000080E7, 1'b0, 0, 0);
      run_instr("sw_wait",    32'h0020A023, 1'b0, 2, 1);

      // Reset during a FETCH wait cycle drops mem_req immediately.
      mem_ready = 1'b0;
      #1;
      check("fetch_wait", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), MAll);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MAll);
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("rst_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MAll);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("rst_fetch", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), MAll);
      @(negedge clk);

      for (int n = 0; n < 150; n++) begin
         do begin
            ri      = $urandom;
            ri[6:0] = opcs[$urandom_range(0, 9)];
`ifdef RISCV_MC_CTRL_TRAP_EN
         end while (!is_legal(ri));
`else
         end while (1'b0);
`endif
         run_instr("random", ri, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   $urandom_range(0, 2));
      end

      // Illegal opcode: NOP path by default, sticky TRAP when the feature is built in.
      run_instr("illegal", 32'h0000007F, 1'b0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle control sequencer for the RV32I core. Decodes the latched instruction register, steps a six-state FSM (IDLE, FETCH, DECODE, EXEC, MEM, WB), and drives every datapath strobe and mux select. Its outputs include the 3-bit immediate-format select consumed by the immediate generator. It owns the single shared memory port, using a req/ready handshake for both instruction fetch and data access.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ir  in  32  instruction register contents; the datapath loads it on ir_we
- mem_ready  in  1  memory port accepted and completed the current request this cycle
- br_taken  in  1  datapath comparator result for the funct3 of the branch in ir
- pc_we  out  1  PC write enable
- pc_src  out  2  00 = PC+4, 01 = ALU result, 10 = ALU result with bit 0 cleared (JALR)
- ir_we  out  1  load ir from memory read data, and latch old_pc = PC
- imm_sel  out  3  001 = I, 010 = S, 011 = B, 100 = U, 101 = J, 000 = none
- alu_a_sel  out  1  0 = rs1, 1 = old_pc
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 = add, 01 = funct3/funct7 decoded, 10 = pass B
- mem_req  out  1  memory request valid
- mem_we  out  1  store when set, load otherwise
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- rf_we  out  1  register-file write enable
- wb_sel  out  2  00 = ALU, 01 = load data, 10 = PC (already PC+4)
- state  out  3  IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6
- trap  out  1  illegal instruction flag; present only with the configuration macro

## Operation
- **IDLE:** all outputs 0. Next state is FETCH unconditionally.
- **FETCH:** mem_req = 1, mem_addr_sel = 0. Hold while mem_ready = 0. On mem_ready: ir_we = 1, pc_we = 1, pc_src = 00, next DECODE.
- **DECODE:** imm_sel is driven from the ir opcode. No strobes. Next EXEC, or TRAP when illegal and the macro is set.
- **EXEC**, by opcode:
  - OP (0110011): alu_op = 01, b = rs2 → WB.
  - OP-IMM (0010011): alu_op = 01, b = imm, imm_sel = 001 → WB.
  - LOAD (0000011) and STORE (0100011): alu_op = 00, b = imm, imm_sel = 001 (load) or 010 (store) → MEM.
  - BRANCH (1100011): a = old_pc, b = imm, imm_sel = 011, pc_we = br_taken, pc_src = 01 → FETCH.
  - JAL (1101111): a = old_pc, imm_sel = 101, pc_we = 1, pc_src = 01, rf_we = 1, wb_sel = 10 → FETCH.
  - JALR (1100111): a = rs1, imm_sel = 001, pc_src = 10, plus the same pc_we, rf_we and wb_sel as JAL → FETCH.
  - LUI (0110111): imm_sel = 100, alu_op = 10 → WB.
  - AUIPC (0010111): a = old_pc, imm_sel = 100, alu_op = 00 → WB.
- **MEM:** mem_req = 1, mem_addr_sel = 1, mem_we = (opcode == STORE). Hold until mem_ready. Then a load goes to WB and a store goes to FETCH.
- **WB:** rf_we = 1. wb_sel = 01 for a load, 00 otherwise. Next FETCH.
- In every state, imm_sel and alu selects stay stable for the whole state.

## Timing
- state is registered. All other outputs are combinational from state and ir, with no output registers.
- Reset: state = IDLE, so every output is 0 while rst_n is low. Reset assertion mid-request drops mem_req asynchronously.
- Latency with mem_ready tied to 1:
  - branch, JAL, JALR: 3 cycles
  - store, OP, OP-IMM, LUI, AUIPC: 4 cycles
  - load: 5 cycles
- Each memory wait cycle adds 1 cycle. While waiting, mem_req and mem_we are held constant.
- mem_req is never asserted in two consecutive accesses without an intervening state change.
- mem_ready sampled outside FETCH or MEM is ignored.
- ir must not change except via ir_we. ir_we is asserted only in FETCH.
- A write with rd = x0 is still strobed. The register file discards it.

## Configuration
- RISCV_MC_CTRL_TRAP_EN:
  - **Defined:** an opcode not listed above, or funct3 reserved for BRANCH/LOAD/STORE, sends DECODE → TRAP.
  - **TRAP behaviour:** trap = 1 and all other strobes are 0. TRAP is sticky until rst_n.
  - **Undefined:** the trap port is absent. Illegal instructions take DECODE → EXEC → FETCH with no strobes, behaving as a NOP, and the PC has already advanced.

## Test plan
- **ADD, zero-wait memory:** states 1, 2, 3, 5, 1 are visited. rf_we = 1 only in WB with wb_sel = 00. ir_we and pc_we pulse once, in FETCH.
- **LW with mem_ready low for 2 cycles in MEM:** MEM lasts 3 cycles with mem_req = 1 and mem_we = 0 throughout. WB then shows wb_sel = 01.
- **BEQ:** with br_taken = 1, EXEC shows pc_we = 1, pc_src = 01, imm_sel = 011. With br_taken = 0, pc_we = 0. Both take 3 cycles total.
- **JALR:** EXEC shows imm_sel = 001, pc_src = 10, rf_we = 1, wb_sel = 10, alu_a_sel = 0.
- **Reset mid-FETCH:** rst_n falls during a wait cycle. mem_req drops immediately and state = 0. After release: IDLE for 1 cycle, then FETCH.
- **Illegal opcode 0x0000007F:** with the macro defined, TRAP is reached and trap stays 1 for 10+ cycles. Without the macro, the sequence is 2 → 3 → 1 with no strobes.
